// File: rtl/cache_line_writeback_if.sv
// Evict-request and AXI4 write-channel bundle for the victim writeback engine.
interface cache_line_writeback_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 8
);

  // Evict request from the cache controller
  logic                             req_valid;
  logic                             req_ready;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [DATA_WIDTH*LINE_WORDS-1:0] req_line;

  // Status back to the cache controller
  logic                             busy;
  logic                             done;
  logic                             err;

  // AXI4 write address channel
  logic [ADDR_WIDTH-1:0]            m_awaddr;
  logic [7:0]                       m_awlen;
  logic [2:0]                       m_awsize;
  logic [1:0]                       m_awburst;
  logic                             m_awvalid;
  logic                             m_awready;

  // AXI4 write data channel
  logic [DATA_WIDTH-1:0]            m_wdata;
  logic [DATA_WIDTH/8-1:0]          m_wstrb;
  logic                             m_wlast;
  logic                             m_wvalid;
  logic                             m_wready;

  // AXI4 write response channel
  logic [1:0]                       m_bresp;
  logic                             m_bvalid;
  logic                             m_bready;

  // Engine side: accepts evicts, masters the AXI write channels
  modport master (
    input  req_valid, req_addr, req_line,
    output req_ready, busy, done, err,
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  // Environment side: cache controller plus AXI slave
  modport slave (
    output req_valid, req_addr, req_line,
    input  req_ready, busy, done, err,
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );

endinterface

// File: rtl/cache_line_writeback.sv
// Victim writeback engine: latches one evicted cache line and drains it as a
// single AXI4 INCR write burst (AW, then LINE_WORDS W beats, then B).
module cache_line_writeback #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  cache_line_writeback_if.master  bus
);

  localparam int unsigned LINE_BYTES = LINE_WORDS * DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam int unsigned CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned LAST_BEAT  = LINE_WORDS - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_line [LINE_WORDS];
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wlast;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_req_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_awaddr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  w_wlast_nxt;
  logic                  w_awvalid_nxt;
  logic                  w_wvalid_nxt;
  logic                  w_bready_nxt;
  logic                  w_req_ready_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_awaddr_nxt = r_awaddr;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept     = 1'b1;
          w_cnt_nxt    = '0;
          w_awaddr_nxt = {bus.req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
          w_state_nxt  = S_AW;
        end
      end
      S_AW: begin
        if (bus.m_awready) begin
          w_state_nxt = S_W;
        end
      end
      S_W: begin
        if (bus.m_wready) begin
          if (r_cnt == CNT_W'(LAST_BEAT)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_B;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_B: begin
        if (bus.m_bvalid) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = (bus.m_bresp != 2'b00);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_awvalid_nxt   = (w_state_nxt == S_AW);
    w_wvalid_nxt    = (w_state_nxt == S_W);
    w_wlast_nxt     = w_wvalid_nxt && (w_cnt_nxt == CNT_W'(LAST_BEAT));
    w_wdata_nxt     = w_wvalid_nxt ? r_line[w_cnt_nxt] : r_wdata;
    w_bready_nxt    = (w_state_nxt == S_B);
    // Hold off new requests during the done cycle so accept never overlaps done
    w_req_ready_nxt = (w_state_nxt == S_IDLE) && !w_done_nxt;
    w_busy_nxt      = (w_state_nxt != S_IDLE) || w_done_nxt;
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wlast     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wlast     <= w_wlast_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Line buffer: captured only on accept, so later req_line changes are ignored
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        r_line[k] <= bus.req_line[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

  assign bus.m_awaddr  = r_awaddr;
  assign bus.m_awlen   = 8'(LINE_WORDS - 1);
  assign bus.m_awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign bus.m_awburst = 2'b01;
  assign bus.m_awvalid = r_awvalid;

  assign bus.m_wdata   = r_wdata;
  assign bus.m_wstrb   = '1;
  assign bus.m_wlast   = r_wlast;
  assign bus.m_wvalid  = r_wvalid;

  assign bus.m_bready  = r_bready;

endmodule

// File: tb/tb_cache_line_writeback.sv
// Bench for cache_line_writeback: directed scenarios followed by randomized bursts,
// checked against a transaction-level model of the expected AXI write burst.
module tb_cache_line_writeback;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  typedef logic [DW*LW-1:0] line_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cache_line_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) bus ();

  cache_line_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Scenario knobs consumed by run_burst
  logic [AW-1:0] c_addr;
  line_t         c_line;
  int            c_aw_dly;
  int            c_wmode;     // 0: wready high, 1: toggle 1,0,.. 2: random
  logic [1:0]    c_bresp;
  int            c_b_dly;
  int            c_rst_beat;  // beat index at which reset is asserted, -1 for none
  bit            c_keep;      // keep req_valid high with the next request after accept
  logic [AW-1:0] c_nxt_addr;
  line_t         c_nxt_line;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic line_t mk_line(input logic [31:0] base, input bit rnd);
    line_t l;
    for (int k = 0; k < int'(LW); k++) begin
      l[k*DW +: DW] = rnd ? DW'($urandom) : (base + DW'(k));
    end
    return l;
  endfunction

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_req_ready"}, bus.req_ready, 1);
    chk({pfx, "_busy"},      bus.busy, 0);
    chk({pfx, "_done"},      bus.done, 0);
    chk({pfx, "_err"},       bus.err, 0);
    chk({pfx, "_awvalid"},   bus.m_awvalid, 0);
    chk({pfx, "_wvalid"},    bus.m_wvalid, 0);
    chk({pfx, "_wlast"},     bus.m_wlast, 0);
    chk({pfx, "_bready"},    bus.m_bready, 0);
    chk({pfx, "_awaddr"},    bus.m_awaddr, 0);
    chk({pfx, "_wdata"},     bus.m_wdata, 0);
  endtask

  // One evict: drive request, play AXI slave, compare against expected burst
  task automatic run_burst();
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr;
    int  t, acc_cyc, aw_wait, b_wait, stalls, exp_lat;
    bit  aw_done, b_done, tog, wr;

    exp_addr = c_addr - (c_addr % (LW * DW / 8));
    for (int k = 0; k < int'(LW); k++) exp_q.push_back(c_line[k*DW +: DW]);

    bus.req_valid = 1'b1;
    bus.req_addr  = c_addr;
    bus.req_line  = c_line;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;

    t = 0;
    while (bus.req_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("req_ready_at_accept", bus.req_ready, 1);
    acc_cyc = cyc;
    step();

    if (c_keep) begin
      bus.req_addr = c_nxt_addr;
      bus.req_line = c_nxt_line;
    end else begin
      bus.req_valid = 1'b0;
      bus.req_line  = mk_line(0, 1);
    end

    aw_done = 0; b_done = 0; aw_wait = 0; b_wait = 0; stalls = 0; tog = 1;
    for (int it = 0; it < 200; it++) begin
      chk("busy", bus.busy, 1);
      chk("req_ready_busy", bus.req_ready, 0);
      if (b_done) begin
        chk("done", bus.done, 1);
        chk("err", bus.err, (c_bresp != 2'b00));
        chk("bready_after_b", bus.m_bready, 0);
        exp_lat = 3 + int'(LW) + c_aw_dly + stalls + c_b_dly;
        chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        bus.m_bvalid = 1'b0;
        step();
        chk("done_pulse_end", bus.done, 0);
        chk("err_pulse_end", bus.err, 0);
        chk("busy_end", bus.busy, 0);
        chk("req_ready_end", bus.req_ready, 1);
        return;
      end
      chk("done_early", bus.done, 0);
      if (!aw_done) begin
        chk("awvalid", bus.m_awvalid, 1);
        chk("awaddr", bus.m_awaddr, exp_addr);
        chk("awlen", bus.m_awlen, LW - 1);
        chk("awsize", bus.m_awsize, 2);
        chk("awburst", bus.m_awburst, 1);
        chk("wvalid_before_aw", bus.m_wvalid, 0);
        bus.m_awready = (aw_wait >= c_aw_dly);
        aw_wait++;
        aw_done = bus.m_awready && bus.m_awvalid;
      end else if (exp_q.size() > 0) begin
        bus.m_awready = 1'b0;
        chk("awvalid_in_w", bus.m_awvalid, 0);
        chk("wvalid", bus.m_wvalid, 1);
        chk("wdata", bus.m_wdata, exp_q[0]);
        chk("wlast", bus.m_wlast, (exp_q.size() == 1));
        chk("wstrb", bus.m_wstrb, 4'hF);
        if (c_rst_beat == int'(LW) - exp_q.size()) begin
          rst = 1'b1;
          bus.m_wready = 1'b1;
          step();
          rst = 1'b0;
          bus.m_wready = 1'b0;
          chk_quiet("mid_rst");
          return;
        end
        case (c_wmode)
          0:       wr = 1'b1;
          1:       begin wr = tog; tog = !tog; end
          default: wr = 1'($urandom_range(0, 1));
        endcase
        bus.m_wready = wr;
        if (!wr) stalls++;
        if (wr && bus.m_wvalid) void'(exp_q.pop_front());
      end else begin
        bus.m_wready = 1'b0;
        chk("wvalid_in_b", bus.m_wvalid, 0);
        chk("bready", bus.m_bready, 1);
        bus.m_bresp  = c_bresp;
        bus.m_bvalid = (b_wait >= c_b_dly);
        b_wait++;
        b_done = bus.m_bvalid && bus.m_bready;
      end
      step();
    end
    chk("burst_timeout", 0, 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_line  = '0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;
    bus.m_bresp   = 2'b00;
    c_aw_dly = 0; c_wmode = 0; c_bresp = 2'b00; c_b_dly = 0;
    c_rst_beat = -1; c_keep = 0; c_nxt_addr = '0; c_nxt_line = '0;

    repeat (3) step();
    chk_quiet("reset");
    chk("reset_awlen", bus.m_awlen, 7);
    chk("reset_wstrb", bus.m_wstrb, 4'hF);
    rst = 1'b0;
    step();
    chk("post_reset_req_ready", bus.req_ready, 1);

    // Basic burst with all readies high
    c_addr = 32'h1000_0014;
    c_line = mk_line(32'hA0, 0);
    run_burst();

    // wready toggling
    c_addr = $urandom; c_line = mk_line(0, 1); c_wmode = 1;
    run_burst();

    // awready delayed five cycles
    c_addr = $urandom; c_line = mk_line(0, 1); c_wmode = 0; c_aw_dly = 5;
    run_burst();

    // SLVERR response
    c_addr = $urandom; c_line = mk_line(0, 1); c_aw_dly = 0; c_bresp = 2'b10; c_b_dly = 2;
    run_burst();

    // Back-to-back with req_valid held and req_line changed mid-burst
    c_bresp = 2'b00; c_b_dly = 0; c_keep = 1;
    c_addr = $urandom; c_line = mk_line(0, 1);
    c_nxt_addr = $urandom; c_nxt_line = mk_line(32'hB0, 0);
    run_burst();
    c_keep = 0; c_addr = c_nxt_addr; c_line = c_nxt_line;
    run_burst();

    // Reset on beat 3, then a clean request
    c_addr = $urandom; c_line = mk_line(0, 1); c_rst_beat = 3;
    run_burst();
    c_rst_beat = -1; c_addr = $urandom; c_line = mk_line(0, 1);
    run_burst();

    // Randomized bursts
    for (int i = 0; i < 20; i++) begin
      c_addr   = $urandom;
      c_line   = mk_line(0, 1);
      c_aw_dly = int'($urandom_range(0, 3));
      c_wmode  = int'($urandom_range(0, 2));
      c_bresp  = 2'($urandom);
      c_b_dly  = int'($urandom_range(0, 3));
      run_burst();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
